oc8051_stack_seq: RTL and testbench

//   Stack access sequencer: the consumer side of the stack pointer. It turns byte push/pop and
//   16-bit call/return requests into timed internal-RAM write/read cycles and owns the SP

---
 rtl/oc8051_stack_seq.sv | 140 ++++++++++++++
 tb/tb_oc8051_stack_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oc8051_stack_seq.sv
// Stack access sequencer: owns SP and turns push/pop/call/ret requests into
// timed internal-RAM write and read cycles; SP is also writable as an SFR.
module oc8051_stack_seq #(
   parameter logic [7:0] RST_SP      = 8'h07,
   parameter logic [7:0] SFR_SP_ADDR = 8'h81
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_data,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   input  logic        sfr_wr,
   input  logic        sfr_wr_bit,
   input  logic [7:0]  sfr_addr,
   input  logic [7:0]  sfr_data,
   output logic [7:0]  sp_out,
   output logic        ram_wr,
   output logic [7:0]  ram_wr_addr,
   output logic [7:0]  ram_wr_data,
   output logic        ram_rd,
   output logic [7:0]  ram_rd_addr,
   input  logic [7:0]  ram_rd_data
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_LO   = 3'd1;
   localparam logic [2:0] S_WR_HI   = 3'd2;
   localparam logic [2:0] S_RD_A    = 3'd3;
   localparam logic [2:0] S_RD_B    = 3'd4;
   localparam logic [2:0] S_RD_DONE = 3'd5;

   localparam logic [1:0] OP_CALL = 2'b10;
   localparam logic [1:0] OP_RET  = 2'b11;

   logic [2:0]  state_q, state_d;
   logic [7:0]  sp_q, sp_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] data_q, data_d;
   logic [7:0]  hi_q, hi_d;
   logic [15:0] rsp_q, rsp_d;

   logic        sp_hit;
   logic [7:0]  sp_inc;
   logic [7:0]  sp_dec;
   logic [15:0] rsp_word;

   assign sp_hit    = sfr_wr & ~sfr_wr_bit & (sfr_addr == SFR_SP_ADDR);
   assign sp_inc    = sp_q + 8'd1;
   assign sp_dec    = sp_q - 8'd1;
   assign req_ready = (state_q == S_IDLE) & ~sp_hit;
   assign sp_out    = sp_q;

   always_comb begin
      state_d     = state_q;
      sp_d        = sp_q;
      op_d        = op_q;
      data_d      = data_q;
      hi_d        = hi_q;
      rsp_d       = rsp_q;
      rsp_word    = rsp_q;
      rsp_valid   = 1'b0;
      ram_wr      = 1'b0;
      ram_wr_addr = 8'h00;
      ram_wr_data = 8'h00;
      ram_rd      = 1'b0;
      ram_rd_addr = 8'h00;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               op_d    = req_op;
               data_d  = req_data;
               // op bit 0 distinguishes reads (pop8/ret) from writes (push8/call)
               state_d = req_op[0] ? S_RD_A : S_WR_LO;
            end
         end
         S_WR_LO: begin
            ram_wr      = 1'b1;
            ram_wr_addr = sp_inc;
            ram_wr_data = data_q[7:0];
            sp_d        = sp_inc;
            state_d     = (op_q == OP_CALL) ? S_WR_HI : S_IDLE;
         end
         S_WR_HI: begin
            ram_wr      = 1'b1;
            ram_wr_addr = sp_inc;
            ram_wr_data = data_q[15:8];
            sp_d        = sp_inc;
            state_d     = S_IDLE;
         end
         S_RD_A: begin
            ram_rd      = 1'b1;
            ram_rd_addr = sp_q;
            sp_d        = sp_dec;
            state_d     = (op_q == OP_RET) ? S_RD_B : S_RD_DONE;
         end
         S_RD_B: begin
            ram_rd      = 1'b1;
            ram_rd_addr = sp_q;
            hi_d        = ram_rd_data;
            sp_d        = sp_dec;
            state_d     = S_RD_DONE;
         end
         S_RD_DONE: begin
            // Response is presented straight from the RAM in this cycle and held afterwards
            rsp_valid = 1'b1;
            rsp_word  = (op_q == OP_RET) ? {hi_q, ram_rd_data} : {8'h00, ram_rd_data};
            rsp_d     = rsp_word;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (sp_hit) sp_d = sfr_data;
   end

   assign rsp_data = rsp_valid ? rsp_word : rsp_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sp_q    <= RST_SP;
         op_q    <= 2'b00;
         data_q  <= 16'h0000;
         hi_q    <= 8'h00;
         rsp_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
         op_q    <= op_d;
         data_q  <= data_d;
         hi_q    <= hi_d;
         rsp_q   <= rsp_d;
      end
   end

endmodule

// File: tb/tb_oc8051_stack_seq.sv
// Bench for oc8051_stack_seq: directed scenarios followed by random stack traffic,
// checked against a byte-array stack model with an SP counter.
module tb_oc8051_stack_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_data;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        sfr_wr;
   logic        sfr_wr_bit;
   logic [7:0]  sfr_addr;
   logic [7:0]  sfr_data;
   logic [7:0]  sp_out;
   logic        ram_wr;
   logic [7:0]  ram_wr_addr;
   logic [7:0]  ram_wr_data;
   logic        ram_rd;
   logic [7:0]  ram_rd_addr;
   logic [7:0]  ram_rd_data;

   localparam logic [1:0] PUSH8 = 2'b00;
   localparam logic [1:0] POP8  = 2'b01;
   localparam logic [1:0] CALL  = 2'b10;
   localparam logic [1:0] RET   = 2'b11;

   always #5 clk = ~clk;

   oc8051_stack_seq dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .sfr_wr(sfr_wr), .sfr_wr_bit(sfr_wr_bit), .sfr_addr(sfr_addr), .sfr_data(sfr_data),
      .sp_out(sp_out),
      .ram_wr(ram_wr), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_rd(ram_rd), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
   );

   // Internal RAM: synchronous write, read data registered one cycle after ram_rd
   logic [7:0] ram [256];
   always @(posedge clk) begin
      if (ram_wr) ram[ram_wr_addr] <= ram_wr_data;
      if (ram_rd) ram_rd_data <= ram[ram_rd_addr];
   end

   // Reference model: stack bytes by address, which addresses hold known data, and SP
   logic [7:0] m_mem [256];
   bit         m_val [256];
   logic [7:0] m_sp;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_push(input logic [7:0] b);
      m_sp = m_sp + 8'd1;
      m_mem[m_sp] = b;
      m_val[m_sp] = 1'b1;
   endtask

   task automatic chk_wr(input string tag, input logic [7:0] addr, input logic [7:0] data);
      chk({tag, "_stb"}, 16'({ram_wr, ram_rd}), 16'b10);
      chk({tag, "_addr"}, 16'(ram_wr_addr), 16'(addr));
      chk({tag, "_data"}, 16'(ram_wr_data), 16'(data));
   endtask

   task automatic chk_rd(input string tag, input logic [7:0] addr);
      chk({tag, "_stb"}, 16'({ram_wr, ram_rd}), 16'b01);
      chk({tag, "_addr"}, 16'(ram_rd_addr), 16'(addr));
   endtask

   task automatic do_op(input logic [1:0] op, input logic [15:0] d);
      logic [15:0] exp_v;
      exp_v = 16'h0000;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_data  = d;
      #1 chk("accept_ready", 16'(req_ready), 16'd1);
      @(negedge clk);
      req_valid = 1'b0;
      req_data  = 16'($urandom);
      #1;
      case (op)
         PUSH8, CALL: begin
            chk_wr("wr_lo", m_sp + 8'd1, d[7:0]);
            m_push(d[7:0]);
            if (op == CALL) begin
               @(negedge clk); #1;
               chk_wr("wr_hi", m_sp + 8'd1, d[15:8]);
               m_push(d[15:8]);
            end
         end
         POP8: begin
            chk_rd("pop_rd", m_sp);
            exp_v = {8'h00, m_mem[m_sp]};
            m_sp  = m_sp - 8'd1;
            @(negedge clk); #1;
            chk("pop_rsp_valid", 16'(rsp_valid), 16'd1);
            chk("pop_rsp_data", rsp_data, exp_v);
         end
         default: begin
            chk_rd("ret_rd_hi", m_sp);
            exp_v[15:8] = m_mem[m_sp];
            m_sp = m_sp - 8'd1;
            @(negedge clk); #1;
            chk_rd("ret_rd_lo", m_sp);
            chk("ret_early_valid", 16'(rsp_valid), 16'd0);
            exp_v[7:0] = m_mem[m_sp];
            m_sp = m_sp - 8'd1;
            @(negedge clk); #1;
            chk("ret_rsp_valid", 16'(rsp_valid), 16'd1);
            chk("ret_rsp_data", rsp_data, exp_v);
         end
      endcase
      @(negedge clk); #1;
      chk("done_ready", 16'(req_ready), 16'd1);
      chk("done_rsp_valid", 16'(rsp_valid), 16'd0);
      chk("done_sp", 16'(sp_out), 16'(m_sp));
      if (op[0]) chk("rsp_hold", rsp_data, exp_v);
   endtask

   // SP written through the SFR port while a request is offered in IDLE
   task automatic set_sp(input logic [7:0] v);
      @(negedge clk);
      sfr_wr     = 1'b1;
      sfr_wr_bit = 1'b0;
      sfr_addr   = 8'h81;
      sfr_data   = v;
      req_valid  = 1'b1;
      req_op     = PUSH8;
      #1 chk("sfr_blocks_ready", 16'(req_ready), 16'd0);
      @(negedge clk);
      sfr_wr    = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("sfr_sp", 16'(sp_out), 16'(v));
      chk("sfr_no_accept", 16'({ram_wr, ram_rd}), 16'd0);
      m_sp = v;
   endtask

   initial begin
      logic [1:0] op;
      int         r;
      rst        = 1'b0;
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_data   = 16'h0000;
      sfr_wr     = 1'b0;
      sfr_wr_bit = 1'b0;
      sfr_addr   = 8'h00;
      sfr_data   = 8'h00;
      m_sp       = 8'h07;
      for (int i = 0; i < 256; i++) begin
         m_mem[i] = 8'h00;
         m_val[i] = 1'b0;
      end

      repeat (3) @(negedge clk);
      #1;
      chk("rst_sp", 16'(sp_out), 16'h0007);
      chk("rst_ready", 16'(req_ready), 16'd1);
      chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
      chk("rst_rsp_data", rsp_data, 16'h0000);
      chk("rst_strobes", 16'({ram_wr, ram_rd}), 16'd0);
      chk("rst_addrs", {ram_wr_addr, ram_rd_addr}, 16'h0000);
      chk("rst_wdata", 16'(ram_wr_data), 16'h0000);
      @(negedge clk);
      rst = 1'b1;

      // call then ret of 16'h1234 from SP=07
      do_op(CALL, 16'h1234);
      chk("call_sp09", 16'(sp_out), 16'h0009);
      do_op(RET, 16'h0000);
      chk("ret_sp07", 16'(sp_out), 16'h0007);

      // SP wraparound on push and pop
      set_sp(8'hFF);
      do_op(PUSH8, 16'h00A5);
      chk("wrap_push_sp", 16'(sp_out), 16'h0000);
      do_op(POP8, 16'h0000);
      chk("wrap_pop_sp", 16'(sp_out), 16'h00FF);

      // bit-qualified write and wrong address leave SP alone
      @(negedge clk);
      sfr_wr = 1'b1; sfr_wr_bit = 1'b1; sfr_addr = 8'h81; sfr_data = 8'h55;
      #1 chk("bitwr_ready", 16'(req_ready), 16'd1);
      @(negedge clk);
      sfr_wr_bit = 1'b0; sfr_addr = 8'h80;
      @(negedge clk);
      sfr_wr = 1'b0;
      #1 chk("bitwr_sp", 16'(sp_out), 16'(m_sp));

      // SP overwritten to 40 during WR_LO of a call
      @(negedge clk);
      req_valid = 1'b1; req_op = CALL; req_data = 16'hBEEF;
      @(negedge clk);
      req_valid = 1'b0;
      sfr_wr = 1'b1; sfr_addr = 8'h81; sfr_data = 8'h40;
      #1 chk_wr("hit_wr_lo", m_sp + 8'd1, 8'hEF);
      m_push(8'hEF);
      m_sp = 8'h40;
      @(negedge clk);
      sfr_wr = 1'b0;
      #1 chk_wr("hit_wr_hi", 8'h41, 8'hBE);
      m_push(8'hBE);
      @(negedge clk);
      #1 chk("hit_sp41", 16'(sp_out), 16'h0041);
      chk("hit_ready", 16'(req_ready), 16'd1);

      // reset in RD_B of a ret
      @(negedge clk);
      req_valid = 1'b1; req_op = RET;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_strobes", 16'({ram_wr, ram_rd}), 16'd0);
      chk("midrst_sp", 16'(sp_out), 16'h0007);
      chk("midrst_ready", 16'(req_ready), 16'd1);
      chk("midrst_rsp_valid", 16'(rsp_valid), 16'd0);
      @(negedge clk);
      rst = 1'b1;
      m_sp = 8'h07;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("postrst_no_rsp", 16'(rsp_valid), 16'd0);
      end

      // random traffic; pops only from addresses the model knows
      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 9) set_sp(8'($urandom));
         else begin
            op = 2'(r % 4);
            if (op == POP8 && !m_val[m_sp]) op = PUSH8;
            if (op == RET && !(m_val[m_sp] && m_val[8'(m_sp - 8'd1)])) op = CALL;
            do_op(op, 16'($urandom));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
